bit_interval_ctr: RTL and testbench

//  Parametrised bit-interval / frame counter for the serial link. Counts baud

---
 rtl/bit_interval_ctr.sv | 107 ++++++++++
 tb/tb_bit_interval_ctr.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bit_interval_ctr.sv
// Bit-interval / frame counter: turns baud sample ticks into per-bit strobes,
// a mid-bit sampling strobe and frame-level completion/abort pulses.
module bit_interval_ctr #(
    parameter int DATA_BITS       = 8,
    parameter int PARITY_EN       = 0,
    parameter int STOP_BITS       = 1,
    parameter int SAMPLES_PER_BIT = 16,
    parameter int CONTINUOUS      = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       transmit_enable,
    input  logic       baud_tick,
    output logic       busy,
    output logic [3:0] bit_idx,
    output logic       bit_boundary,
    output logic       sample_mid,
    output logic       char_sent,
    output logic       frame_abort
);

    localparam int FRAME_BITS = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int CW         = (SAMPLES_PER_BIT > 2) ? $clog2(SAMPLES_PER_BIT) : 1;

    localparam logic [CW-1:0] MID_CNT  = CW'(SAMPLES_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SAMPLES_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'(FRAME_BITS - 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic          bnd_q, bnd_d;
    logic          mid_q, mid_d;
    logic          sent_q, sent_d;
    logic          abort_q, abort_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bnd_d   = 1'b0;
        mid_d   = 1'b0;
        sent_d  = 1'b0;
        abort_d = 1'b0;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            idx_d = '0;
            if (transmit_enable) state_d = ST_RUN;
        end else begin
            // Abort takes priority, even over the final tick of a frame.
            if (!transmit_enable) begin
                state_d = ST_IDLE;
                abort_d = 1'b1;
                cnt_d   = '0;
                idx_d   = '0;
            end else if (baud_tick) begin
                if (cnt_q == MID_CNT) begin
                    mid_d = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                end else if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    bnd_d = 1'b1;
                    if (idx_q < LAST_BIT) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        sent_d = 1'b1;
                        idx_d  = '0;
                        if (CONTINUOUS == 0) state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bnd_q   <= 1'b0;
            mid_q   <= 1'b0;
            sent_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bnd_q   <= bnd_d;
            mid_q   <= mid_d;
            sent_q  <= sent_d;
            abort_q <= abort_d;
        end
    end

    assign busy         = (state_q == ST_RUN);
    assign bit_idx      = idx_q;
    assign bit_boundary = bnd_q;
    assign sample_mid   = mid_q;
    assign char_sent    = sent_q;
    assign frame_abort  = abort_q;

endmodule

// File: tb/tb_bit_interval_ctr.sv
// Directed bench for bit_interval_ctr: default, continuous and 7E2-style
// frame configurations, each on its own instance sharing one clock.
module tb_bit_interval_ctr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic       te  [3];
    logic       tk  [3];
    logic       busy[3];
    logic [3:0] idx [3];
    logic       bnd [3];
    logic       mid [3];
    logic       snt [3];
    logic       abt [3];

    bit_interval_ctr u0 (
        .clk(clk), .reset(rst[0]), .transmit_enable(te[0]), .baud_tick(tk[0]),
        .busy(busy[0]), .bit_idx(idx[0]), .bit_boundary(bnd[0]),
        .sample_mid(mid[0]), .char_sent(snt[0]), .frame_abort(abt[0]));

    bit_interval_ctr #(.CONTINUOUS(1)) u1 (
        .clk(clk), .reset(rst[1]), .transmit_enable(te[1]), .baud_tick(tk[1]),
        .busy(busy[1]), .bit_idx(idx[1]), .bit_boundary(bnd[1]),
        .sample_mid(mid[1]), .char_sent(snt[1]), .frame_abort(abt[1]));

    bit_interval_ctr #(.DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) u2 (
        .clk(clk), .reset(rst[2]), .transmit_enable(te[2]), .baud_tick(tk[2]),
        .busy(busy[2]), .bit_idx(idx[2]), .bit_boundary(bnd[2]),
        .sample_mid(mid[2]), .char_sent(snt[2]), .frame_abort(abt[2]));

    typedef struct {
        logic       rst, te, tk;
        logic       busy;
        logic [3:0] idx;
        logic       bnd, mid, snt, abt;
    } vec_t;

    vec_t vt[$];
    int   errors = 0;
    int   checks = 0;

    task automatic add(input logic r, input logic e, input logic k, input logic b,
                       input logic [3:0] i, input logic bd, input logic m,
                       input logic s, input logic a);
        vec_t v;
        v.rst = r; v.te = e; v.tk = k; v.busy = b; v.idx = i;
        v.bnd = bd; v.mid = m; v.snt = s; v.abt = a;
        vt.push_back(v);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input int d, input logic r, input logic e, input logic k);
        rst[d] = r; te[d] = e; tk[d] = k;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input int d, input string tag, input int eb, input int ei,
                             input int ebd, input int em, input int es, input int ea);
        chk($sformatf("%s busy", tag), int'(busy[d]), eb);
        chk($sformatf("%s bit_idx", tag), int'(idx[d]), ei);
        chk($sformatf("%s bit_boundary", tag), int'(bnd[d]), ebd);
        chk($sformatf("%s sample_mid", tag), int'(mid[d]), em);
        chk($sformatf("%s char_sent", tag), int'(snt[d]), es);
        chk($sformatf("%s frame_abort", tag), int'(abt[d]), ea);
    endtask

    // Reset, then the enable cycle that moves the FSM into RUN.
    task automatic start(input int d, input string tag);
        drive(d, 1, 0, 0); step();
        drive(d, 0, 1, 0); step();
        check_out(d, tag, 1, 0, 0, 0, 0, 0);
    endtask

    // Tick every cycle for n ticks with enable held; expected values from tick arithmetic.
    task automatic run_ticks(input int d, input string tag, input int n, input int frame,
                             input int spb, input int cont);
        for (int t = 1; t <= n; t++) begin
            drive(d, 0, 1, 1); step();
            check_out(d, $sformatf("%s t%0d", tag, t),
                      (cont != 0 || t % frame != 0) ? 1 : 0,
                      (t % frame) / spb,
                      (t % spb == 0) ? 1 : 0,
                      (t % spb == spb / 2) ? 1 : 0,
                      (t % frame == 0) ? 1 : 0, 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) drive(d, 1, 0, 0);

        // Reset with enable high, enable cycle, partial bit, hold, boundary, abort.
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(0, 1, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            drive(0, vt[i].rst, vt[i].te, vt[i].tk);
            step();
            check_out(0, $sformatf("vec%0d", i), vt[i].busy, vt[i].idx,
                      vt[i].bnd, vt[i].mid, vt[i].snt, vt[i].abt);
        end

        // Full default frame, then IDLE lasts one cycle before re-entering RUN.
        start(0, "frame_en");
        run_ticks(0, "frame", 160, 160, 16, 0);
        drive(0, 0, 1, 1); step();
        check_out(0, "reenter", 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0); step();
        check_out(0, "reenter_abort", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0); step();
        check_out(0, "abort_1cyc", 0, 0, 0, 0, 0, 0);

        // Slow ticks: one every third cycle over two bit intervals.
        begin
            int n;
            start(0, "slow_en");
            n = 0;
            for (int c = 1; c <= 96; c++) begin
                logic k;
                k = (c % 3 == 0);
                if (k) n++;
                drive(0, 0, 1, k); step();
                check_out(0, $sformatf("slow c%0d", c), 1, n / 16,
                          (k && n % 16 == 0) ? 1 : 0, (k && n % 16 == 8) ? 1 : 0, 0, 0);
            end
        end

        // Abort after tick 50.
        start(0, "ab50_en");
        for (int t = 1; t <= 50; t++) begin drive(0, 0, 1, 1); step(); end
        check_out(0, "ab50_pre", 1, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0); step();
        check_out(0, "ab50", 0, 0, 0, 0, 0, 1);
        step();
        check_out(0, "ab50_after", 0, 0, 0, 0, 0, 0);

        // Enable drops on the final tick: abort wins, no char_sent.
        start(0, "ab160_en");
        for (int t = 1; t <= 159; t++) begin drive(0, 0, 1, 1); step(); end
        drive(0, 0, 0, 1); step();
        check_out(0, "ab160", 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0); step();
        check_out(0, "ab160_after", 0, 0, 0, 0, 0, 0);

        // Continuous frames: busy never drops, bit_idx wraps.
        start(1, "cont_en");
        run_ticks(1, "cont", 320, 160, 16, 1);

        // 11-bit frame (7 data, parity, 2 stop).
        start(2, "f11_en");
        run_ticks(2, "f11", 176, 176, 16, 0);
        drive(2, 0, 0, 0); step();
        check_out(2, "f11_idle", 0, 0, 0, 0, 0, 0);

        // Reset mid-frame at tick 90.
        start(2, "rst90_en");
        for (int t = 1; t <= 89; t++) begin drive(2, 0, 1, 1); step(); end
        check_out(2, "rst90_pre", 1, 5, 0, 0, 0, 0);
        drive(2, 1, 1, 1); step();
        check_out(2, "rst90", 0, 0, 0, 0, 0, 0);
        drive(2, 0, 0, 1); step();
        check_out(2, "rst90_after", 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
